// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 2x16 character frame buffer with terminal-style byte decode and an async read port.
// Optional build macro LCD_TB_SCROLL_EN: a newline on row 1 scrolls instead of wrapping to row 0.
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic [7:0] addr,
  input  logic       rd,
  output logic [7:0] data,
  output logic       cur_row,
  output logic [3:0] cur_col
);

  localparam int unsigned NCELLS = 32;
  localparam int unsigned IDX_W  = 5;
  localparam int unsigned COL_W  = 4;

`ifdef LCD_TB_SCROLL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_CLRLINE, ST_SCROLL} state_e;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_CLRLINE} state_e;
`endif

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               tgt_q, tgt_d;
  logic [7:0]         cell_q [NCELLS];
  logic [7:0]         cell_d [NCELLS];
  logic               nl;
  logic [COL_W-1:0]   col_m1;
  logic               rd_unused;

  // rd is a driver-side strobe only; reads are never gated by it
  assign rd_unused = rd;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      row_q   <= 1'b0;
      col_q   <= '0;
      tgt_q   <= 1'b0;
      cell_q  <= '{default: FILL_CHAR};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      tgt_q   <= tgt_d;
      cell_q  <= cell_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    tgt_d   = tgt_q;
    cell_d  = cell_q;
    nl      = 1'b0;
    col_m1  = col_q - COL_W'(1);
    case (state_q)
      ST_IDLE: begin
        idx_d = '0;
        if (char_valid) begin
          if (char_in >= 8'h20 && char_in <= 8'h7E) begin
            cell_d[{row_q, col_q}] = char_in;
            if (col_q == COL_W'(15)) nl = 1'b1;
            else                     col_d = col_q + COL_W'(1);
          end else begin
            case (char_in)
              8'h0A: nl = 1'b1;
              8'h0D: col_d = '0;
              8'h08: begin
                if (col_q != '0) begin
                  col_d = col_m1;
                  cell_d[{row_q, col_m1}] = FILL_CHAR;
                end
              end
              8'h0C:   state_d = ST_CLEAR;
              default: ;
            endcase
          end
          // Cursor moves on the accept edge; the line wipe follows in its own state
          if (nl) begin
            col_d = '0;
            if (!row_q) begin
              row_d   = 1'b1;
              tgt_d   = 1'b1;
              state_d = ST_CLRLINE;
            end else begin
`ifdef LCD_TB_SCROLL_EN
              state_d = ST_SCROLL;
`else
              row_d   = 1'b0;
              tgt_d   = 1'b0;
              state_d = ST_CLRLINE;
`endif
            end
          end
        end
      end
      ST_CLEAR: begin
        cell_d[idx_q] = FILL_CHAR;
        if (idx_q == IDX_W'(NCELLS - 1)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          row_d   = 1'b0;
          col_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_CLRLINE: begin
        cell_d[{tgt_q, idx_q[COL_W-1:0]}] = FILL_CHAR;
        if (idx_q[COL_W-1:0] == COL_W'(15)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`ifdef LCD_TB_SCROLL_EN
      ST_SCROLL: begin
        cell_d[{1'b0, idx_q[COL_W-1:0]}] = cell_q[{1'b1, idx_q[COL_W-1:0]}];
        cell_d[{1'b1, idx_q[COL_W-1:0]}] = FILL_CHAR;
        if (idx_q[COL_W-1:0] == COL_W'(15)) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Driver read port: only 0x00-0x0F and 0x40-0x4F map to cells
  always_comb begin
    data = FILL_CHAR;
    if (!addr[7] && addr[5:4] == 2'b00) data = cell_q[{addr[6], addr[3:0]}];
  end

  assign char_ready = (state_q == ST_IDLE);
  assign cur_row    = row_q;
  assign cur_col    = col_q;

endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: directed vectors with hand-computed expectations for lcd_text_buffer.
module tb_lcd_text_buffer;

  logic       clk = 1'b0;
  logic       resetn;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [7:0] addr;
  logic       rd;
  logic [7:0] data;
  logic       cur_row;
  logic [3:0] cur_col;

  int n_vec = 0;
  int n_err = 0;

  lcd_text_buffer #(.FILL_CHAR(8'h20)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .addr       (addr),
    .rd         (rd),
    .data       (data),
    .cur_row    (cur_row),
    .cur_col    (cur_col)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
    addr = a;
    rd   = 1'b1;
    #1;
    check_eq($sformatf("%s@%02h", tag, a), 32'(data), 32'(exp));
    rd   = 1'b0;
  endtask

  task automatic row_chk(input string tag, input logic [7:0] base, input logic [7:0] exp);
    for (int i = 0; i < 16; i++) rd_chk(tag, base + 8'(i), exp);
  endtask

  task automatic cur_chk(input string tag, input logic r, input logic [3:0] c);
    check_eq({tag, "_row"}, 32'(cur_row), 32'(r));
    check_eq({tag, "_col"}, 32'(cur_col), 32'(c));
  endtask

  // Holds the byte until the buffer is ready, then drops valid after the accept edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    char_in    = b;
    char_valid = 1'b1;
    n = 0;
    while (!char_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_wait", 32'(char_ready), 32'd1);
    @(posedge clk);
    #1;
    char_valid = 1'b0;
  endtask

  task automatic busy_chk(input string tag, input int exp);
    int n;
    n = 0;
    while (!char_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq(tag, 32'(n), 32'(exp));
  endtask

  logic [7:0] rb;

  initial begin
    resetn     = 1'b0;
    char_in    = 8'h00;
    char_valid = 1'b0;
    addr       = 8'h00;
    rd         = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // T1 reset state
    row_chk("rst_r0", 8'h00, 8'h20);
    row_chk("rst_r1", 8'h40, 8'h20);
    check_eq("rst_ready", 32'(char_ready), 32'd1);
    cur_chk("rst", 1'b0, 4'd0);

    // T2 printable
    send_byte(8'h48);
    check_eq("t2_ready0", 32'(char_ready), 32'd1);
    send_byte(8'h49);
    check_eq("t2_ready1", 32'(char_ready), 32'd1);
    rd_chk("t2", 8'h00, 8'h48);
    rd_chk("t2", 8'h01, 8'h49);
    cur_chk("t2", 1'b0, 4'd2);

    // T3 wrap from column 0
    send_byte(8'h0D);
    cur_chk("t3_cr", 1'b0, 4'd0);
    for (int i = 0; i < 15; i++) send_byte(8'h41);
    check_eq("t3_ready15", 32'(char_ready), 32'd1);
    cur_chk("t3_c15", 1'b0, 4'd15);
    send_byte(8'h41);
    busy_chk("t3_busy", 16);
    row_chk("t3_r0", 8'h00, 8'h41);
    row_chk("t3_r1", 8'h40, 8'h20);
    cur_chk("t3", 1'b1, 4'd0);

    // T4 newline on row 1
    send_byte(8'h42);
    send_byte(8'h42);
    send_byte(8'h42);
    rd_chk("t4_pre", 8'h42, 8'h42);
    cur_chk("t4_pre", 1'b1, 4'd3);
    send_byte(8'h0A);
    busy_chk("t4_busy", 16);
`ifdef LCD_TB_SCROLL_EN
    for (int i = 0; i < 3; i++) rd_chk("t4_r0", 8'(i), 8'h42);
    for (int i = 3; i < 16; i++) rd_chk("t4_r0", 8'(i), 8'h20);
    row_chk("t4_r1", 8'h40, 8'h20);
    cur_chk("t4", 1'b1, 4'd0);
    rb = 8'h40;
`else
    row_chk("t4_r0", 8'h00, 8'h20);
    for (int i = 0; i < 3; i++) rd_chk("t4_r1", 8'h40 + 8'(i), 8'h42);
    for (int i = 3; i < 16; i++) rd_chk("t4_r1", 8'h40 + 8'(i), 8'h20);
    cur_chk("t4", 1'b0, 4'd0);
    rb = 8'h00;
`endif

    // T5 BS / CR / BS at col 0 / ignored byte / FF
    send_byte(8'h43);
    send_byte(8'h44);
    send_byte(8'h45);
    rd_chk("t5_e", rb + 8'd2, 8'h45);
    send_byte(8'h08);
    check_eq("t5_bs_ready", 32'(char_ready), 32'd1);
    check_eq("t5_bs_col", 32'(cur_col), 32'd2);
    rd_chk("t5_bs", rb + 8'd2, 8'h20);
    rd_chk("t5_bs", rb + 8'd1, 8'h44);
    send_byte(8'h0D);
    check_eq("t5_cr_col", 32'(cur_col), 32'd0);
    send_byte(8'h08);
    check_eq("t5_bs0_col", 32'(cur_col), 32'd0);
    rd_chk("t5_bs0", rb, 8'h43);
    send_byte(8'h01);
    check_eq("t5_ign_ready", 32'(char_ready), 32'd1);
    check_eq("t5_ign_col", 32'(cur_col), 32'd0);
    rd_chk("t5_ign", rb, 8'h43);
    send_byte(8'h0C);
    busy_chk("t5_ff_busy", 32);
    row_chk("t5_ff_r0", 8'h00, 8'h20);
    row_chk("t5_ff_r1", 8'h40, 8'h20);
    cur_chk("t5_ff", 1'b0, 4'd0);

    // T6 unmapped addresses must not alias onto cells
    send_byte(8'h5A);
    rd_chk("t6_cell", 8'h00, 8'h5A);
    rd_chk("t6_unmap", 8'h20, 8'h20);
    rd_chk("t6_unmap", 8'h8F, 8'h20);
    rd_chk("t6_unmap", 8'h80, 8'h20);
    rd_chk("t6_unmap", 8'h10, 8'h20);
    rd_chk("t6_unmap", 8'hC0, 8'h20);

    // T6 reset in the middle of CLEAR
    send_byte(8'h0A);
    busy_chk("t6_lf_busy", 16);
    send_byte(8'h51);
    rd_chk("t6_q", 8'h40, 8'h51);
    cur_chk("t6_q", 1'b1, 4'd1);
    send_byte(8'h0C);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("t6_rst_ready", 32'(char_ready), 32'd1);
    cur_chk("t6_rst", 1'b0, 4'd0);
    rd_chk("t6_rst", 8'h40, 8'h20);
    rd_chk("t6_rst", 8'h00, 8'h20);
    @(negedge clk);
    resetn = 1'b1;

    // T6 byte held through a busy period is taken exactly once
    send_byte(8'h0A);
    check_eq("t6_hold_busy", 32'(char_ready), 32'd0);
    send_byte(8'h4B);
    rd_chk("t6_hold", 8'h40, 8'h4B);
    rd_chk("t6_hold", 8'h41, 8'h20);
    cur_chk("t6_hold", 1'b1, 4'd1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("t6_hold_col2", 32'(cur_col), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
